// File: rtl/alu_station_pkg.sv
// Shared types for the ALU reservation station: operation names, default widths
// and the layout of one station entry.
package alu_station_pkg;

  localparam int XLEN_DEFAULT  = 32;
  localparam int TAG_W_DEFAULT = 6;
  localparam int DEPTH_DEFAULT = 4;

  typedef enum logic [4:0] {
    ADD, SUB, AND, OR, XOR, SLL, SRL, SRA, SLT, SLTU,
    ADDI, ANDI, ORI, XORI, SLLI, SRLI, SRAI, SLTI, SLTIU,
    LUI, AUIPC
  } instr_name_t;

  // Entry widths follow the package defaults; override XLEN/TAG_W here, not only on the top.
  typedef struct packed {
    instr_name_t                instr;
    logic [XLEN_DEFAULT-1:0]    address;
    logic [XLEN_DEFAULT-1:0]    immediate;
    logic                       src_1_valid;
    logic [TAG_W_DEFAULT-1:0]   tag_1;
    logic [XLEN_DEFAULT-1:0]    data_1;
    logic                       src_2_valid;
    logic [TAG_W_DEFAULT-1:0]   tag_2;
    logic [XLEN_DEFAULT-1:0]    data_2;
    logic [TAG_W_DEFAULT-1:0]   dest_tag;
  } station_entry_t;

endpackage

// File: rtl/station_unit_if.sv
// Operand/result bundle between an issue station and its execution unit.
interface station_unit_if
  import alu_station_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
);
  instr_name_t     instr;
  logic [XLEN-1:0] address;
  logic [XLEN-1:0] immediate;
  logic [XLEN-1:0] data_1;
  logic [XLEN-1:0] data_2;
  logic [XLEN-1:0] result;

  modport station (output instr, address, immediate, data_1, data_2, input result);
  modport unit    (input instr, address, immediate, data_1, data_2, output result);
endinterface

// File: rtl/alu.sv
// Purely combinational integer ALU; LUI expects an already-shifted immediate.
module alu
  import alu_station_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  station_unit_if.unit bus
);
  localparam int SH_W = $clog2(XLEN);

  logic [SH_W-1:0] shamt_r;
  logic [SH_W-1:0] shamt_i;

  assign shamt_r = bus.data_2[SH_W-1:0];
  assign shamt_i = bus.immediate[SH_W-1:0];

  always_comb begin
    bus.result = '0;
    case (bus.instr)
      ADD:   bus.result = bus.data_1 + bus.data_2;
      SUB:   bus.result = bus.data_1 - bus.data_2;
      AND:   bus.result = bus.data_1 & bus.data_2;
      OR:    bus.result = bus.data_1 | bus.data_2;
      XOR:   bus.result = bus.data_1 ^ bus.data_2;
      SLL:   bus.result = bus.data_1 << shamt_r;
      SRL:   bus.result = bus.data_1 >> shamt_r;
      SRA:   bus.result = $signed(bus.data_1) >>> shamt_r;
      SLT:   bus.result = {{(XLEN-1){1'b0}}, $signed(bus.data_1) < $signed(bus.data_2)};
      SLTU:  bus.result = {{(XLEN-1){1'b0}}, bus.data_1 < bus.data_2};
      ADDI:  bus.result = bus.data_1 + bus.immediate;
      ANDI:  bus.result = bus.data_1 & bus.immediate;
      ORI:   bus.result = bus.data_1 | bus.immediate;
      XORI:  bus.result = bus.data_1 ^ bus.immediate;
      SLLI:  bus.result = bus.data_1 << shamt_i;
      SRLI:  bus.result = bus.data_1 >> shamt_i;
      SRAI:  bus.result = $signed(bus.data_1) >>> shamt_i;
      SLTI:  bus.result = {{(XLEN-1){1'b0}}, $signed(bus.data_1) < $signed(bus.immediate)};
      SLTIU: bus.result = {{(XLEN-1){1'b0}}, bus.data_1 < bus.immediate};
      LUI:   bus.result = bus.immediate;
      AUIPC: bus.result = bus.address + bus.immediate;
      default: bus.result = '0;
    endcase
  end
endmodule

// File: rtl/alu_select.sv
// Oldest-first pick: one-hot grant on the lowest-index ready entry.
module alu_select #(
  parameter int DEPTH = 4
) (
  input  logic [DEPTH-1:0] ready,
  output logic [DEPTH-1:0] grant,
  output logic             any_ready
);
  always_comb begin
    grant     = '0;
    any_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ready[i] && !any_ready) begin
        grant[i]  = 1'b1;
        any_ready = 1'b1;
      end
    end
  end
endmodule

// File: rtl/alu_station.sv
// ALU reservation station: collapsing queue of waiting instructions, CDB wakeup,
// oldest-ready issue into the ALU and a result register held until CDB grant.
module alu_station
  import alu_station_pkg::*;
#(
  parameter int XLEN  = XLEN_DEFAULT,
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int TAG_W = TAG_W_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              disp_valid,
  output logic              disp_ready,
  input  instr_name_t       disp_instr_name,
  input  logic [XLEN-1:0]   disp_address,
  input  logic [XLEN-1:0]   disp_immediate,
  input  logic              disp_src_1_valid,
  input  logic              disp_src_2_valid,
  input  logic [XLEN-1:0]   disp_data_1,
  input  logic [XLEN-1:0]   disp_data_2,
  input  logic [TAG_W-1:0]  disp_tag_1,
  input  logic [TAG_W-1:0]  disp_tag_2,
  input  logic [TAG_W-1:0]  disp_dest_tag,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [XLEN-1:0]   cdb_data,
  output logic              res_req,
  input  logic              res_grant,
  output logic [TAG_W-1:0]  res_tag,
  output logic [XLEN-1:0]   res_data
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  station_entry_t    entries_q [DEPTH];
  station_entry_t    entries_d [DEPTH];
  station_entry_t    woken     [DEPTH];
  station_entry_t    new_entry;
  station_entry_t    sel_entry;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [CNT_W-1:0]  ins_pos;
  logic              res_req_q, res_req_d;
  logic [TAG_W-1:0]  res_tag_q, res_tag_d;
  logic [XLEN-1:0]   res_data_q, res_data_d;
  logic [DEPTH-1:0]  ready_vec;
  logic [DEPTH-1:0]  issue_oh;
  logic              any_ready;
  logic              issue;
  logic              accept;
  logic              shift;

  assign disp_ready = count_q < CNT_W'(DEPTH);
  assign accept     = disp_valid && disp_ready;
  assign issue      = (!res_req_q || res_grant) && any_ready;

  // Readiness uses stored operand state only, so a CDB capture issues a cycle later.
  always_comb begin
    ready_vec = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ready_vec[i] = (CNT_W'(i) < count_q) && entries_q[i].src_1_valid &&
                     entries_q[i].src_2_valid;
    end
  end

  alu_select #(.DEPTH(DEPTH)) u_select (
    .ready     (ready_vec),
    .grant     (issue_oh),
    .any_ready (any_ready)
  );

  always_comb begin
    sel_entry = entries_q[0];
    for (int i = 0; i < DEPTH; i++) begin
      if (issue_oh[i]) sel_entry = entries_q[i];
    end
  end

  station_unit_if #(.XLEN(XLEN)) alu_bus ();

  assign alu_bus.instr     = sel_entry.instr;
  assign alu_bus.address   = sel_entry.address;
  assign alu_bus.immediate = sel_entry.immediate;
  assign alu_bus.data_1    = sel_entry.data_1;
  assign alu_bus.data_2    = sel_entry.data_2;

  alu #(.XLEN(XLEN)) u_alu (.bus(alu_bus));

  always_comb begin
    new_entry.instr       = disp_instr_name;
    new_entry.address     = disp_address;
    new_entry.immediate   = disp_immediate;
    new_entry.src_1_valid = disp_src_1_valid;
    new_entry.tag_1       = disp_tag_1;
    new_entry.data_1      = disp_data_1;
    new_entry.src_2_valid = disp_src_2_valid;
    new_entry.tag_2       = disp_tag_2;
    new_entry.data_2      = disp_data_2;
    new_entry.dest_tag    = disp_dest_tag;
    if (!disp_src_1_valid && cdb_valid && (disp_tag_1 == cdb_tag)) begin
      new_entry.src_1_valid = 1'b1;
      new_entry.data_1      = cdb_data;
    end
    if (!disp_src_2_valid && cdb_valid && (disp_tag_2 == cdb_tag)) begin
      new_entry.src_2_valid = 1'b1;
      new_entry.data_2      = cdb_data;
    end

    for (int i = 0; i < DEPTH; i++) begin
      woken[i] = entries_q[i];
      if (cdb_valid && !entries_q[i].src_1_valid && (entries_q[i].tag_1 == cdb_tag)) begin
        woken[i].src_1_valid = 1'b1;
        woken[i].data_1      = cdb_data;
      end
      if (cdb_valid && !entries_q[i].src_2_valid && (entries_q[i].tag_2 == cdb_tag)) begin
        woken[i].src_2_valid = 1'b1;
        woken[i].data_2      = cdb_data;
      end
    end

    // Entries above the issuing slot slide down one place to keep age order.
    shift = 1'b0;
    for (int i = 0; i < DEPTH; i++) entries_d[i] = woken[i];
    for (int i = 0; i < DEPTH - 1; i++) begin
      shift = shift | (issue && issue_oh[i]);
      if (shift) entries_d[i] = woken[i+1];
    end

    ins_pos = count_q - {{(CNT_W-1){1'b0}}, issue};
    if (accept) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (CNT_W'(i) == ins_pos) entries_d[i] = new_entry;
      end
    end
    count_d = count_q - {{(CNT_W-1){1'b0}}, issue} + {{(CNT_W-1){1'b0}}, accept};

    res_req_d  = res_req_q;
    res_tag_d  = res_tag_q;
    res_data_d = res_data_q;
    if (issue) begin
      res_req_d  = 1'b1;
      res_tag_d  = sel_entry.dest_tag;
      res_data_d = alu_bus.result;
    end else if (res_grant) begin
      res_req_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      count_q    <= '0;
      res_req_q  <= 1'b0;
      res_tag_q  <= '0;
      res_data_q <= '0;
      for (int i = 0; i < DEPTH; i++) entries_q[i] <= '0;
    end else begin
      count_q    <= count_d;
      res_req_q  <= res_req_d;
      res_tag_q  <= res_tag_d;
      res_data_q <= res_data_d;
      for (int i = 0; i < DEPTH; i++) entries_q[i] <= entries_d[i];
    end
  end

  assign res_req  = res_req_q;
  assign res_tag  = res_tag_q;
  assign res_data = res_data_q;
endmodule
